// File: rtl/uart_byte_rx.sv
// UART byte receiver: start, 8 data bits LSB first, even parity, stop; reports parity/framing errors.
// Optional build macro UART_RX_MAJORITY_EN enables a 3-sample majority vote around mid-bit.
module uart_byte_rx #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       Clk,
  input  logic       Rst_n,
  input  logic [2:0] baud_set,
  input  logic       Rs232_Rx,
  output logic [7:0] data_byte,
  output logic       Rx_Done,
  output logic       Parity_Err,
  output logic       Frame_Err,
  output logic       uart_state
);

  localparam int unsigned CNT_W  = 16;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned IDX_W  = 4;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t                   state_q, state_d;
  logic [SYNC_STAGES-1:0]   sync_q;
  logic                     rx_prev_q;
  logic [CNT_W-1:0]         dr_q, dr_d;
  logic [CNT_W-1:0]         div_cnt_q, div_cnt_d;
  logic [IDX_W-1:0]         bit_idx_q, bit_idx_d;
  logic [DATA_W-1:0]        shift_q, shift_d;
  logic                     p_rx_q, p_rx_d;
  logic [DATA_W-1:0]        data_q, data_d;
  logic                     done_q, done_d;
  logic                     perr_q, perr_d;
  logic                     ferr_q, ferr_d;
  logic                     busy_q, busy_d;

  logic                     rx_s;
  logic                     rx_ahead;
  logic                     start_edge;
  logic [CNT_W-1:0]         mid;
  logic                     at_mid;
  logic                     wrap;
  logic                     bit_val;
  logic [CNT_W-1:0]         baud_dr;

  // rx_ahead is the value rx_s takes next cycle, so the decision can register at mid
  // and become visible exactly when div_cnt reaches mid+1.
  assign rx_s       = sync_q[SYNC_STAGES-1];
  assign rx_ahead   = sync_q[SYNC_STAGES-2];
  assign start_edge = rx_prev_q & ~rx_s;
  assign mid        = dr_q >> 1;
  assign at_mid     = (div_cnt_q == mid);
  assign wrap       = (div_cnt_q == dr_q);

`ifdef UART_RX_MAJORITY_EN
  logic s_m1_q, s_m1_d;

  assign s_m1_d  = (div_cnt_q == (mid - CNT_W'(1))) ? rx_s : s_m1_q;
  assign bit_val = (s_m1_q & rx_s) | (s_m1_q & rx_ahead) | (rx_s & rx_ahead);

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) s_m1_q <= 1'b1;
    else        s_m1_q <= s_m1_d;
  end
`else
  assign bit_val = rx_ahead;
`endif

  // Bit-period divisor shared with the transmitter's baud_set encoding.
  always_comb begin
    case (baud_set)
      3'd0:    baud_dr = CNT_W'(5207);
      3'd1:    baud_dr = CNT_W'(2603);
      3'd2:    baud_dr = CNT_W'(1301);
      3'd3:    baud_dr = CNT_W'(867);
      3'd4:    baud_dr = CNT_W'(433);
      default: baud_dr = CNT_W'(5207);
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q   <= IDLE;
      sync_q    <= '1;
      rx_prev_q <= 1'b1;
      dr_q      <= CNT_W'(5207);
      div_cnt_q <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      p_rx_q    <= 1'b0;
      data_q    <= '0;
      done_q    <= 1'b0;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      sync_q    <= {sync_q[SYNC_STAGES-2:0], Rs232_Rx};
      rx_prev_q <= rx_s;
      dr_q      <= dr_d;
      div_cnt_q <= div_cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      p_rx_q    <= p_rx_d;
      data_q    <= data_d;
      done_q    <= done_d;
      perr_q    <= perr_d;
      ferr_q    <= ferr_d;
      busy_q    <= busy_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    dr_d      = dr_q;
    div_cnt_d = div_cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    p_rx_d    = p_rx_q;
    data_d    = data_q;
    done_d    = 1'b0;
    perr_d    = perr_q;
    ferr_d    = ferr_q;
    busy_d    = busy_q;

    if (state_q != IDLE) begin
      div_cnt_d = wrap ? '0 : div_cnt_q + CNT_W'(1);
    end

    case (state_q)
      IDLE: begin
        dr_d = baud_dr;
        if (start_edge) begin
          div_cnt_d = '0;
          bit_idx_d = '0;
          busy_d    = 1'b1;
          state_d   = START;
        end
      end
      START: begin
        if (at_mid && bit_val) begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end else if (wrap) begin
          state_d = DATA;
        end
      end
      DATA: begin
        if (at_mid) begin
          shift_d = {bit_val, shift_q[DATA_W-1:1]};
        end
        if (wrap) begin
          if (bit_idx_q == IDX_W'(DATA_W - 1)) begin
            state_d = PARITY;
          end else begin
            bit_idx_d = bit_idx_q + IDX_W'(1);
          end
        end
      end
      PARITY: begin
        if (at_mid) begin
          p_rx_d = bit_val;
        end
        if (wrap) begin
          state_d = STOP;
        end
      end
      STOP: begin
        // Return to IDLE at mid-stop so a back-to-back start bit is not missed.
        if (at_mid) begin
          done_d  = 1'b1;
          data_d  = shift_q;
          perr_d  = p_rx_q ^ (^shift_q);
          ferr_d  = ~bit_val;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  assign data_byte  = data_q;
  assign Rx_Done    = done_q;
  assign Parity_Err = perr_q;
  assign Frame_Err  = ferr_q;
  assign uart_state = busy_q;

endmodule

// File: tb/tb_uart_byte_rx.sv
// Bench for uart_byte_rx: table of frames driven by an emulated transmitter, scoreboard-checked on Rx_Done.
module tb_uart_byte_rx;

  localparam int SYNC = 2;

  logic       Clk = 1'b0;
  logic       Rst_n = 1'b0;
  logic [2:0] baud_set = 3'd4;
  logic       Rs232_Rx = 1'b1;
  logic [7:0] data_byte;
  logic       Rx_Done;
  logic       Parity_Err;
  logic       Frame_Err;
  logic       uart_state;

  typedef struct {
    logic [2:0] baud;
    logic [7:0] data;
    bit         flip_par;
    bit         stop_val;
    bit         chg_baud;
  } vec_t;

  typedef struct {
    logic [7:0]  data;
    bit          perr;
    bit          ferr;
    int unsigned done_cyc;
  } exp_t;

  exp_t        sb[$];
  int unsigned cyc = 0;
  int          n_tests = 0;
  int          n_fail = 0;
  logic        prev_done = 1'b0;
  logic [7:0]  last_data = 8'h00;

  uart_byte_rx #(.SYNC_STAGES(SYNC)) dut (
    .Clk        (Clk),
    .Rst_n      (Rst_n),
    .baud_set   (baud_set),
    .Rs232_Rx   (Rs232_Rx),
    .data_byte  (data_byte),
    .Rx_Done    (Rx_Done),
    .Parity_Err (Parity_Err),
    .Frame_Err  (Frame_Err),
    .uart_state (uart_state)
  );

  always #5 Clk = ~Clk;

  always @(posedge Clk) cyc <= cyc + 1;

  function automatic int period(input logic [2:0] b);
    case (b)
      3'd1:    return 2604;
      3'd2:    return 1302;
      3'd3:    return 868;
      3'd4:    return 434;
      default: return 5208;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  // Scoreboard consumer: every Rx_Done must match the oldest expected frame.
  always @(negedge Clk) begin
    exp_t e;
    if (Rst_n && Rx_Done) begin
      check("done_not_back_to_back", 32'(prev_done), 32'd0);
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_done: got data %0h expected no strobe (cycle %0d)", data_byte, cyc);
      end else begin
        e = sb.pop_front();
        check("data_byte", 32'(data_byte), 32'(e.data));
        check("parity_err", 32'(Parity_Err), 32'(e.perr));
        check("frame_err", 32'(Frame_Err), 32'(e.ferr));
        check("done_cycle", cyc, e.done_cyc);
      end
    end
    prev_done = Rx_Done;
  end

  // Emulated transmitter; starts at #1 after a posedge, one line value per clock.
  task automatic send_frame(input vec_t v, input int glitch, input int abort_at, input bit push);
    logic [10:0] bits;
    int          p;
    int          mid;
    exp_t        e;
    p        = period(v.baud);
    mid      = (p - 1) / 2;
    bits     = {v.stop_val, (^v.data) ^ v.flip_par, v.data, 1'b0};
    baud_set = v.baud;
    step();
    step();
    if (push) begin
      e.data     = v.data;
      e.perr     = v.flip_par;
      e.ferr     = ~v.stop_val;
      e.done_cyc = cyc + 32'(SYNC + 10 * p + mid + 2);
      sb.push_back(e);
      last_data  = v.data;
    end
    for (int c = 0; c < 11 * p; c++) begin
      if (abort_at >= 0 && c == abort_at) break;
      Rs232_Rx = (c == glitch) ? 1'b0 : bits[c / p];
      if (v.chg_baud && c == p) baud_set = 3'd0;
      step();
    end
    Rs232_Rx = 1'b1;
    baud_set = v.baud;
    repeat (20) step();
  endtask

  vec_t vecs[6];

  initial begin
    vec_t v;
    int   base;

    vecs[0] = '{baud: 3'd4, data: 8'h00, flip_par: 1'b0, stop_val: 1'b1, chg_baud: 1'b0};
    vecs[1] = '{baud: 3'd4, data: 8'hFF, flip_par: 1'b0, stop_val: 1'b1, chg_baud: 1'b0};
    vecs[2] = '{baud: 3'd4, data: 8'hA5, flip_par: 1'b0, stop_val: 1'b1, chg_baud: 1'b0};
    vecs[3] = '{baud: 3'd4, data: 8'h3C, flip_par: 1'b0, stop_val: 1'b1, chg_baud: 1'b1};
    vecs[4] = '{baud: 3'd3, data: 8'h55, flip_par: 1'b1, stop_val: 1'b1, chg_baud: 1'b0};
    vecs[5] = '{baud: 3'd4, data: 8'h81, flip_par: 1'b0, stop_val: 1'b0, chg_baud: 1'b0};

    repeat (3) @(posedge Clk);
    #1;
    check("rst_data_byte", 32'(data_byte), 32'd0);
    check("rst_rx_done", 32'(Rx_Done), 32'd0);
    check("rst_parity_err", 32'(Parity_Err), 32'd0);
    check("rst_frame_err", 32'(Frame_Err), 32'd0);
    check("rst_uart_state", 32'(uart_state), 32'd0);
    Rst_n = 1'b1;
    repeat (5) step();

    for (int i = 0; i < 6; i++) begin
      send_frame(vecs[i], -1, -1, 1'b1);
      check("frame_drained", 32'(sb.size()), 32'd0);
      check("idle_after_frame", 32'(uart_state), 32'd0);
    end

    // False start: 100-clock low pulse, START decision rejects it.
    baud_set = 3'd4;
    step();
    Rs232_Rx = 1'b0;
    for (int c = 0; c < 300; c++) begin
      if (c == 100) Rs232_Rx = 1'b1;
      @(negedge Clk);
      if (c == SYNC + 1)   check("fs_state_rise", 32'(uart_state), 32'd1);
      if (c == SYNC + 217) check("fs_state_hold", 32'(uart_state), 32'd1);
      if (c == SYNC + 218) check("fs_state_fall", 32'(uart_state), 32'd0);
      step();
    end
    check("fs_data_unchanged", 32'(data_byte), 32'(last_data));
    check("fs_no_done", 32'(sb.size()), 32'd0);

    // Single-clock glitch at div_cnt==mid of data bit 3 (cell 4).
    v    = '{baud: 3'd4, data: 8'hFF, flip_par: 1'b0, stop_val: 1'b1, chg_baud: 1'b0};
    base = 1 + 4 * 434 + 216;
    send_frame(v, base, -1, 1'b1);
    check("glitch_drained", 32'(sb.size()), 32'd0);

    // Reset in the middle of DATA discards the frame.
    v = '{baud: 3'd4, data: 8'h5A, flip_par: 1'b0, stop_val: 1'b1, chg_baud: 1'b0};
    send_frame(v, -1, 3 * 434, 1'b0);
    check("mid_frame_busy", 32'(uart_state), 32'd1);
    Rst_n = 1'b0;
    #2;
    check("arst_data_byte", 32'(data_byte), 32'd0);
    check("arst_rx_done", 32'(Rx_Done), 32'd0);
    check("arst_parity_err", 32'(Parity_Err), 32'd0);
    check("arst_frame_err", 32'(Frame_Err), 32'd0);
    check("arst_uart_state", 32'(uart_state), 32'd0);
    repeat (3) step();
    Rst_n = 1'b1;
    repeat (5) step();
    send_frame(v, -1, -1, 1'b1);
    check("post_reset_drained", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #3000000;
    n_fail++;
    $display("FAIL timeout: got no finish expected finish by cycle %0d", cyc);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "timeout");
  end

endmodule
